// File: rtl/cache_line_mem.sv
// cache_line_mem
//
// Line-granular backing memory that answers the cache's lower interface.
// Each accepted request (whole-line read or write-back) is answered with a
// one-cycle mem_resp after LATENCY cycles. The block also keeps a sticky
// protocol-violation flag and wrapping read/write completion counters.
//
// Ports
//   clk              single clock; all state updates on the rising edge
//   rst              synchronous active-high reset (array contents untouched)
//   mem_read         line read request, held by the initiator until mem_resp
//   mem_write        line write-back request, held until mem_resp
//   mem_address      byte address; line index = mem_address[s_offset +: s_depth]
//   mem_byte_enable  must be 4'b1111; anything else on a write sets error
//   mem_wdata        write-back line data
//   mem_rdata        registered read data, stable until the next read response
//   mem_resp         one-cycle completion pulse
//   error            sticky protocol-violation flag, cleared only by rst
//   rd_count         completed reads (wrapping)
//   wr_count         completed writes (wrapping)
//
// Timing: the edge that accepts a request (state IDLE, request high) loads the
// wait counter with LATENCY-1. WAIT then lasts LATENCY-1 cycles and RESP is
// the LATENCY-th cycle after the accepting edge. With LATENCY=1 the accepting
// edge moves straight to RESP, so mem_resp is high in the very next cycle.

module cache_line_mem #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_depth  = 8,
  parameter int unsigned LATENCY  = 4,
  localparam int unsigned LineW   = 8 * (2 ** s_offset)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      mem_address,
  input  logic [3:0]       mem_byte_enable,
  input  logic [LineW-1:0] mem_wdata,
  output logic [LineW-1:0] mem_rdata,
  output logic             mem_resp,
  output logic             error,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
);

  localparam int unsigned Lines = 2 ** s_depth;

  // Value loaded into the wait counter on acceptance.
  localparam logic [7:0] LatLoad  = 8'(LATENCY - 1);
  localparam logic       Latency1 = (LATENCY == 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [s_depth-1:0] idx_q;
  logic               op_write_q;
  logic [LineW-1:0]   wdata_q;
  logic [LineW-1:0]   rdata_q;
  logic               error_q;
  logic [31:0]        rd_count_q;
  logic [31:0]        wr_count_q;

  logic [LineW-1:0]   mem_array [Lines];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [s_depth-1:0] in_idx;
  logic               req;
  logic               accept;
  logic               accept_err;
  logic               unused_addr;

  assign in_idx = mem_address[s_offset +: s_depth];
  assign req    = mem_read | mem_write;
  assign accept = (state_q == S_IDLE) && req;

  // Offset and upper address bits do not select anything; lines alias.
  assign unused_addr = ^{mem_address[31:s_offset+s_depth], mem_address[s_offset-1:0]};

  // Both requests at once (write wins) or a partial byte enable on a write.
  assign accept_err = accept &&
                      ((mem_read && mem_write) || (mem_write && (mem_byte_enable != 4'b1111)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = LatLoad;
          state_d = Latency1 ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Inputs are not looked at here: a dropped request still completes.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read capture: the line is fetched on the edge that enters RESP so that
  // mem_rdata is valid during the response cycle and registered.
  // ---------------------------------------------------------------------------
  logic [s_depth-1:0] rd_idx;
  logic               rd_op;
  logic               rd_load;

  // With LATENCY=1 RESP is entered from IDLE, so index and op come straight
  // from the inputs rather than from the latched copies.
  assign rd_idx  = (state_q == S_IDLE) ? in_idx : idx_q;
  assign rd_op   = (state_q == S_IDLE) ? !mem_write : !op_write_q;
  assign rd_load = (state_d == S_RESP) && (state_q != S_RESP) && rd_op;

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      op_write_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (accept) begin
        idx_q      <= in_idx;
        op_write_q <= mem_write;
        wdata_q    <= mem_wdata;
      end

      if (accept_err) begin
        error_q <= 1'b1;
      end

      if (rd_load) begin
        rdata_q <= mem_array[rd_idx];
      end

      // Completion counters advance on the edge that ends RESP.
      if (state_q == S_RESP) begin
        if (op_write_q) begin
          wr_count_q <= wr_count_q + 32'd1;
        end else begin
          rd_count_q <= rd_count_q + 32'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line array: never reset. A reset on the edge ending RESP suppresses the
  // write, which aborts the access.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_RESP) && op_write_q) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_resp  = (state_q == S_RESP);
  assign mem_rdata = rdata_q;
  assign error     = error_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_cache_line_mem.sv
module tb_cache_line_mem;

  localparam int LineW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic             mem_read, mem_write;
  logic [31:0]      mem_address;
  logic [3:0]       mem_byte_enable;
  logic [LineW-1:0] mem_wdata, mem_rdata;
  logic             mem_resp, error;
  logic [31:0]      rd_count, wr_count;

  // LATENCY=1 instance
  logic             rd1, wr1;
  logic [31:0]      addr1;
  logic [3:0]       be1;
  logic [LineW-1:0] wd1, rdata1;
  logic             resp1, err1;
  logic [31:0]      rc1, wc1;

  cache_line_mem #(.s_offset(5), .s_depth(8), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .error(error), .rd_count(rd_count), .wr_count(wr_count)
  );

  cache_line_mem #(.s_offset(5), .s_depth(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
    .mem_address(addr1), .mem_byte_enable(be1),
    .mem_wdata(wd1), .mem_rdata(rdata1), .mem_resp(resp1),
    .error(err1), .rd_count(rc1), .wr_count(wc1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one entry per line index, plus expected status.
  logic [LineW-1:0] model_mem [256];
  logic [31:0]      exp_rd, exp_wr;
  logic             exp_err;
  logic [LineW-1:0] exp_rdata;

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[12:5]);
  endfunction

  function automatic logic [LineW-1:0] rand_line();
    logic [LineW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at #1 after a rising edge with the DUT idle. Returns the cycle (1 =
  // first cycle after the accepting edge) in which mem_resp was seen, and ends
  // one edge later in the following idle cycle. Also updates the model.
  task automatic access4(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [LineW-1:0] wd, input bit drop,
                         output logic [LineW-1:0] rdata, output int lat);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    @(posedge clk); #1;
    if (drop) begin
      mem_read = 1'b0; mem_write = 1'b0; mem_address = $urandom;
    end
    lat = 1;
    while (!mem_resp && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = mem_rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    if (wr) begin
      model_mem[idx_of(addr)] = wd;
      exp_wr++;
      if (rd || be != 4'hF) exp_err = 1'b1;
    end else begin
      exp_rdata = model_mem[idx_of(addr)];
      exp_rd++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0; exp_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0; exp_rdata = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (mem_resp !== 1'b0 || resp1 !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle_resp cycle %0d: got %b/%b want 0/0", i, mem_resp, resp1);
      end
    end
    tests++;
    if (mem_rdata !== '0 || error !== 1'b0 || rd_count !== 0 || wr_count !== 0) begin
      fails++;
      $display("FAIL reset_state: rdata=%h err=%b rd=%0d wr=%0d want all 0",
               mem_rdata, error, rd_count, wr_count);
    end
    tests++;
    if (rdata1 !== '0 || err1 !== 1'b0 || rc1 !== 0 || wc1 !== 0) begin
      fails++;
      $display("FAIL reset_state_lat1: rdata=%h err=%b rd=%0d wr=%0d want all 0",
               rdata1, err1, rc1, wc1);
    end
  endtask

  task automatic test_write_read();
    logic [LineW-1:0] rd;
    int lat;
    access4(0, 1, 32'h0000_0040, 4'hF, {32{8'hA5}}, 0, rd, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL wr_latency: got %0d want 4", lat); end
    tests++;
    if (mem_resp !== 1'b0) begin fails++; $display("FAIL resp_pulse_width: got 1 want 0"); end
    access4(1, 0, 32'h0000_0040, 4'hF, '0, 0, rd, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d want 4", lat); end
    tests++;
    if (rd !== {32{8'hA5}}) begin
      fails++; $display("FAIL rd_data_a5: got %h want %h", rd, {32{8'hA5}});
    end
    tests++;
    if (wr_count !== 32'd1 || rd_count !== 32'd1) begin
      fails++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d want 1/1", wr_count, rd_count);
    end
    // A later write must not disturb the registered read data.
    access4(0, 1, 32'h0000_0060, 4'hF, {32{8'h3C}}, 0, rd, lat);
    tests++;
    if (mem_rdata !== {32{8'hA5}}) begin
      fails++; $display("FAIL rdata_hold: got %h want %h", mem_rdata, {32{8'hA5}});
    end
  endtask

  task automatic test_back_to_back();
    logic [LineW-1:0] rd, y, x;
    int lat;
    y = rand_line();
    x = rand_line();
    access4(0, 1, 32'h0000_1000, 4'hF, y, 0, rd, lat);
    access4(0, 1, 32'h0000_2000, 4'hF, x, 0, rd, lat);
    // access4 returns in the idle cycle after RESP, so this read is accepted
    // with no gap.
    access4(1, 0, 32'h0000_1000, 4'hF, '0, 0, rd, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    tests++;
    if (rd !== exp_rdata) begin fails++; $display("FAIL b2b_fill_data: got %h want %h", rd, exp_rdata); end
    tests++;
    if (wr_count !== exp_wr || rd_count !== exp_rd) begin
      fails++; $display("FAIL b2b_counts: got wr=%0d rd=%0d want %0d/%0d",
                        wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_alias();
    logic [LineW-1:0] rd, v;
    int lat;
    v = rand_line();
    access4(0, 1, 32'h0000_0020, 4'hF, v, 0, rd, lat);
    access4(1, 0, 32'h0000_203F, 4'hF, '0, 0, rd, lat);
    tests++;
    if (rd !== v) begin fails++; $display("FAIL alias_offset: got %h want %h", rd, v); end
  endtask

  task automatic test_random();
    logic [LineW-1:0] rd;
    logic [31:0] a;
    int lat;
    int written[$];
    int bad_data = 0, bad_lat = 0;
    for (int n = 0; n < 40; n++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = $urandom;
        written.push_back(idx_of(a));
        access4(0, 1, a, 4'hF, rand_line(), $urandom_range(0, 3) == 0, rd, lat);
      end else begin
        a = $urandom;
        a[12:5] = 8'(written[$urandom_range(0, written.size() - 1)]);
        access4(1, 0, a, 4'hF, '0, $urandom_range(0, 3) == 0, rd, lat);
        tests++;
        if (rd !== exp_rdata) begin
          fails++; bad_data++;
          $display("FAIL rand_read_data addr %h: got %h want %h", a, rd, exp_rdata);
        end
      end
      tests++;
      if (lat !== 4) begin
        fails++; bad_lat++;
        $display("FAIL rand_latency op %0d: got %0d want 4", n, lat);
      end
    end
    tests++;
    if (wr_count !== exp_wr || rd_count !== exp_rd || error !== exp_err) begin
      fails++; $display("FAIL rand_status: got wr=%0d rd=%0d err=%b want %0d/%0d/%b",
                        wr_count, rd_count, error, exp_wr, exp_rd, exp_err);
    end
  endtask

  task automatic test_violations();
    logic [LineW-1:0] rd, v;
    int lat;
    v = rand_line();
    access4(1, 1, 32'h0000_0100, 4'hF, v, 0, rd, lat);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL both_req_error: got %b want 1", error); end
    access4(1, 0, 32'h0000_0100, 4'hF, '0, 0, rd, lat);
    tests++;
    if (rd !== v) begin fails++; $display("FAIL both_req_write_wins: got %h want %h", rd, v); end
    v = rand_line();
    access4(0, 1, 32'h0000_0120, 4'b0011, v, 0, rd, lat);
    access4(1, 0, 32'h0000_0120, 4'hF, '0, 0, rd, lat);
    tests++;
    if (rd !== v || error !== 1'b1) begin
      fails++; $display("FAIL partial_be: got data %h err %b want %h err 1", rd, error, v);
    end
    pulse_reset();
    tests++;
    if (error !== 1'b0 || rd_count !== 0 || wr_count !== 0) begin
      fails++; $display("FAIL error_cleared: got err=%b rd=%0d wr=%0d want 0/0/0",
                        error, rd_count, wr_count);
    end
    // Partial byte enable alone must raise the flag too.
    access4(0, 1, 32'h0000_0140, 4'b0011, rand_line(), 0, rd, lat);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL be_only_error: got %b want 1", error); end
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    logic [LineW-1:0] rd, p;
    int lat;
    int seen;
    p = rand_line();
    access4(0, 1, 32'h0000_0080, 4'hF, p, 0, rd, lat);
    // Write aborted during WAIT.
    mem_write = 1'b1; mem_address = 32'h0000_0080; mem_wdata = rand_line(); mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    pulse_reset();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_resp) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL abort_wait_no_resp: got %0d pulses want 0", seen); end
    // Write aborted in the RESP cycle itself.
    mem_write = 1'b1; mem_wdata = rand_line();
    @(posedge clk); #1;
    mem_write = 1'b0;
    seen = 0;
    while (!mem_resp && seen < 20) begin @(posedge clk); #1; seen++; end
    pulse_reset();
    tests++;
    if (wr_count !== 0 || mem_resp !== 1'b0) begin
      fails++; $display("FAIL abort_resp: got wr=%0d resp=%b want 0/0", wr_count, mem_resp);
    end
    access4(1, 0, 32'h0000_0080, 4'hF, '0, 0, rd, lat);
    tests++;
    if (rd !== p) begin fails++; $display("FAIL abort_keeps_line: got %h want %h", rd, p); end
    tests++;
    if (rd_count !== 1 || wr_count !== 0) begin
      fails++; $display("FAIL abort_counts: got rd=%0d wr=%0d want 1/0", rd_count, wr_count);
    end
  endtask

  task automatic test_latency1();
    logic [LineW-1:0] v;
    int lat;
    v = rand_line();
    for (int k = 0; k < 2; k++) begin
      wr1 = (k == 0); rd1 = (k == 1); addr1 = 32'h0000_0300; be1 = 4'hF; wd1 = v;
      @(posedge clk); #1;
      lat = 1;
      while (!resp1 && lat < 20) begin @(posedge clk); #1; lat++; end
      tests++;
      if (lat !== 1) begin fails++; $display("FAIL lat1_latency op %0d: got %0d want 1", k, lat); end
      if (k == 1) begin
        tests++;
        if (rdata1 !== v) begin fails++; $display("FAIL lat1_data: got %h want %h", rdata1, v); end
      end
      wr1 = 1'b0; rd1 = 1'b0;
      @(posedge clk); #1;
    end
    tests++;
    if (rc1 !== 1 || wc1 !== 1 || err1 !== 1'b0) begin
      fails++; $display("FAIL lat1_status: got rd=%0d wr=%0d err=%b want 1/1/0", rc1, wc1, err1);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_byte_enable = 4'hF; mem_wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; be1 = 4'hF; wd1 = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alias();
    test_random();
    test_violations();
    test_reset_mid();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
